// File: rtl/mem_stage.sv
// Byte-serial MEM stage: loads/stores move one byte per acknowledged request
// over an 8-bit port. Optional macro MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses.
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        in_wd,
  input  logic              in_wreg,
  input  logic [31:0]       in_wdata,
  input  logic [3:0]        in_memop,
  input  logic              in_store,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_sdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  input  logic              mem_ack,
  output logic [4:0]        wb_wd,
  output logic              wb_wreg,
  output logic [31:0]       wb_wdata,
  output logic              stall_req,
  output logic              misalign
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [7:0]        dout;
  } mreq_t;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } wb_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [31:0] lbuf, lbuf_nxt;

  logic        is_mem;
  logic [2:0]  f3;
  logic        supported;
  logic        misaligned;
  logic        go;
  logic [1:0]  last;
  mreq_t       mreq;
  wb_t         wb;
  logic        stall;
  logic        mis_flag;

  assign is_mem = in_memop[3];
  assign f3     = in_memop[2:0];

  always_comb begin
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: supported = 1'b1;
      default:                                supported = 1'b0;
    endcase
  end

  // index of the final byte: 0 for byte, 1 for half, 3 for word
  always_comb begin
    case (f3[1:0])
      2'b00:   last = 2'd0;
      2'b01:   last = 2'd1;
      default: last = 2'd3;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = is_mem && supported &&
                      ((f3[1:0] == 2'b01 && in_addr[0]) ||
                       (f3[1:0] == 2'b10 && in_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign go = is_mem && supported && !misaligned;

  function automatic logic [31:0] extend(input logic [2:0] f, input logic [31:0] b);
    case (f)
      3'b000:  return {{24{b[7]}}, b[7:0]};
      3'b001:  return {{16{b[15]}}, b[15:0]};
      3'b100:  return {24'b0, b[7:0]};
      3'b101:  return {16'b0, b[15:0]};
      default: return b;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
      lbuf  <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      lbuf  <= lbuf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lbuf_nxt  = lbuf;
    mreq      = '0;
    wb.wd     = in_wd;
    wb.wreg   = 1'b0;
    wb.wdata  = in_wdata;
    stall     = 1'b0;
    mis_flag  = 1'b0;
    case (state)
      IDLE: begin
        // any memory-class op (valid, unsupported or rejected) suppresses write-back here
        wb.wreg  = in_wreg && !is_mem;
        mis_flag = misaligned;
        if (go) begin
          stall     = 1'b1;
          state_nxt = XFER;
          cnt_nxt   = 2'd0;
        end
      end
      XFER: begin
        stall     = 1'b1;
        mreq.req  = 1'b1;
        mreq.we   = in_store;
        mreq.a    = in_addr + ADDR_W'(cnt);
        mreq.dout = in_sdata[{cnt, 3'b000} +: 8];
        if (mem_ack) begin
          if (!in_store) lbuf_nxt[{cnt, 3'b000} +: 8] = mem_din;
          if (cnt == last) begin
            state_nxt = DONE;
            cnt_nxt   = 2'd0;
          end else begin
            cnt_nxt   = cnt + 2'd1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        if (!in_store) begin
          wb.wreg  = in_wreg;
          wb.wdata = extend(f3, lbuf);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // reset blanks every output combinationally, including the in-flight request
  assign mem_req   = !rst && mreq.req;
  assign mem_we    = !rst && mreq.we;
  assign mem_a     = rst ? '0 : mreq.a;
  assign mem_dout  = rst ? '0 : mreq.dout;
  assign wb_wd     = rst ? '0 : wb.wd;
  assign wb_wreg   = !rst && wb.wreg;
  assign wb_wdata  = rst ? '0 : wb.wdata;
  assign stall_req = !rst && stall;
  assign misalign  = !rst && mis_flag;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a transaction-level model predicts byte requests,
// stall length and write-back per op; a negedge monitor compares every cycle.
module tb_mem_stage;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        in_wd;
  logic              in_wreg;
  logic [31:0]       in_wdata;
  logic [3:0]        in_memop;
  logic              in_store;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_sdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din;
  logic              mem_ack;
  logic [4:0]        wb_wd;
  logic              wb_wreg;
  logic [31:0]       wb_wdata;
  logic              stall_req;
  logic              misalign;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata), .in_memop(in_memop),
    .in_store(in_store), .in_addr(in_addr), .in_sdata(in_sdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ack(mem_ack),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .stall_req(stall_req), .misalign(misalign)
  );

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic              we;
    logic [7:0]        d;
  } req_t;

  req_t exp_q[$];
  req_t req_log[$];

  int          total = 0;
  int          bad   = 0;
  logic        op_live = 1'b0;
  logic [4:0]  exp_wd;
  logic        exp_wreg;
  logic [31:0] exp_wdata;
  logic        chk_wdata;
  logic        exp_mis;
  int          exp_stall;
  int          stall_cnt;
  logic [31:0] last_wdata;
  logic        last_wreg;
  logic        last_mis;
  int          last_stall;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // What the op must do, from the access rules alone.
  task automatic model(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic [3:0] memop, input logic store, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] ldata, input logic [15:0] waits);
    int          n;
    logic [2:0]  f;
    logic        sup, mis;
    logic [31:0] v;
    f   = memop[2:0];
    sup = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
    n   = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (n == 2 && addr % 2 != 0) || (n == 4 && addr % 4 != 0);
`endif
    exp_q.delete();
    exp_wd    = wd;
    exp_wreg  = wreg;
    exp_wdata = wdata;
    chk_wdata = 1'b1;
    exp_mis   = 1'b0;
    exp_stall = 0;
    if (!memop[3]) begin
      exp_wreg = wreg;
    end else if (!sup) begin
      exp_wreg = 1'b0;
    end else if (mis) begin
      exp_mis   = 1'b1;
      exp_wreg  = 1'b0;
      chk_wdata = 1'b0;
    end else begin
      exp_stall = 1;
      v = 32'd0;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back('{a: ADDR_W'(addr + 32'(i)), we: store, d: 8'(sdata >> (8 * i))});
        exp_stall += 1 + int'(waits[4*i +: 4]);
        v += ((ldata >> (8 * i)) & 32'hFF) << (8 * i);
      end
      if (store) begin
        exp_wreg  = 1'b0;
        chk_wdata = 1'b0;
      end else begin
        if (f == 3'b000)      v = (v ^ 32'h80)   - 32'h80;
        else if (f == 3'b001) v = (v ^ 32'h8000) - 32'h8000;
        exp_wdata = v;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_outputs",
          {mem_req, mem_we, mem_a, mem_dout, wb_wd, wb_wreg, wb_wdata, stall_req, misalign}, '0);
    end else if (op_live) begin
      if (stall_req) begin
        stall_cnt++;
        chk("wreg_in_stall", wb_wreg, 0);
        chk("mis_in_stall", misalign, 0);
        if (mem_req) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_req", mem_req, 0);
          end else begin
            chk("mem_a", mem_a, exp_q[0].a);
            chk("mem_we", mem_we, exp_q[0].we);
            if (exp_q[0].we) chk("mem_dout", mem_dout, exp_q[0].d);
            if (mem_ack) begin
              req_log.push_back('{a: mem_a, we: mem_we, d: mem_dout});
              void'(exp_q.pop_front());
            end
          end
        end
      end else begin
        chk("wb_wd", wb_wd, exp_wd);
        chk("wb_wreg", wb_wreg, exp_wreg);
        if (chk_wdata) chk("wb_wdata", wb_wdata, exp_wdata);
        chk("req_when_free", mem_req, 0);
        chk("misalign", misalign, exp_mis);
        chk("stall_cycles", stall_cnt, exp_stall);
        chk("bytes_left", exp_q.size(), 0);
        last_wdata = wb_wdata;
        last_wreg  = wb_wreg;
        last_mis   = misalign;
        last_stall = stall_cnt;
      end
    end
  end

  // Entered at posedge+1; returns at posedge+1 of the cycle after the result.
  // waits: nibble i = idle request cycles before byte i is acknowledged.
  task automatic do_op(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic [3:0] memop, input logic store, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] ldata,
                       input logic [15:0] waits, input int abort);
    int idx, wl, acks;
    model(wd, wreg, wdata, memop, store, addr, sdata, ldata, waits);
    stall_cnt = 0;
    req_log.delete();
    op_live  = 1'b1;
    in_wd    = wd;
    in_wreg  = wreg;
    in_wdata = wdata;
    in_memop = memop;
    in_store = store;
    in_addr  = addr;
    in_sdata = sdata;
    idx  = 0;
    acks = 0;
    wl   = int'(waits[3:0]);
    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      if (abort >= 0 && acks == abort) begin
        rst     = 1'b1;
        mem_ack = 1'b0;
        exp_q.delete();
        op_live = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (!stall_req) begin
        mem_ack = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (mem_req) begin
        if (wl > 0) begin
          mem_ack = 1'b0;
          wl--;
        end else begin
          mem_ack = 1'b1;
          mem_din = ldata[8*idx +: 8];
          idx++;
          acks++;
          wl = (idx < 4) ? int'(waits[4*idx +: 4]) : 0;
        end
      end else begin
        mem_ack = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("op_timeout", stall_req, 0);
    op_live = 1'b0;
    exp_q.delete();
    rst     = 1'b1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_wd = '0; in_wreg = 1'b0; in_wdata = '0; in_memop = '0;
    in_store = 1'b0; in_addr = '0; in_sdata = '0;
    mem_din = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ALU pass-through
    do_op(5'd5, 1'b1, 32'h1234, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0, -1);
    chk("alu_wdata_lit", last_wdata, 32'h1234);
    chk("alu_stall_lit", last_stall, 0);

    // LB 0x100 -> sign-extended 0x80
    do_op(5'd1, 1'b1, 32'hDEAD, 4'b1000, 1'b0, 32'h100, 32'h0, 32'h80, 16'h0, -1);
    chk("lb_wdata_lit", last_wdata, 32'hFFFFFF80);
    chk("lb_stall_lit", last_stall, 2);
    chk("lb_nreq_lit", req_log.size(), 1);
    chk("lb_addr_lit", req_log[0].a, 32'h100);

    // LW 0x200, byte 1 acknowledged one cycle late
    do_op(5'd2, 1'b1, 32'h0, 4'b1010, 1'b0, 32'h200, 32'h0, 32'h44332211, 16'h0010, -1);
    chk("lw_wdata_lit", last_wdata, 32'h44332211);
    chk("lw_stall_lit", last_stall, 6);

    // SH 0x10
    do_op(5'd3, 1'b1, 32'h55, 4'b1001, 1'b1, 32'h10, 32'hAABBCCDD, 32'h0, 16'h0, -1);
    chk("sh_wreg_lit", last_wreg, 0);
    chk("sh_b0_lit", {req_log[0].a, req_log[0].d}, {32'h10, 8'hDD});
    chk("sh_b1_lit", {req_log[1].a, req_log[1].d}, {32'h11, 8'hCC});

    // remaining load/store flavours
    do_op(5'd4, 1'b1, 32'h0, 4'b1100, 1'b0, 32'h300, 32'h0, 32'h80, 16'h0, -1);
    chk("lbu_wdata_lit", last_wdata, 32'h80);
    do_op(5'd6, 1'b1, 32'h0, 4'b1001, 1'b0, 32'h40, 32'h0, 32'h9234, 16'h0001, -1);
    chk("lh_wdata_lit", last_wdata, 32'hFFFF9234);
    do_op(5'd6, 1'b1, 32'h0, 4'b1101, 1'b0, 32'h40, 32'h0, 32'h9234, 16'h0000, -1);
    chk("lhu_wdata_lit", last_wdata, 32'h00009234);
    do_op(5'd8, 1'b1, 32'h0, 4'b1010, 1'b1, 32'h20, 32'h01020304, 32'h0, 16'h0201, -1);
    chk("sw_stall_lit", last_stall, 8);
    do_op(5'd8, 1'b1, 32'h0, 4'b1000, 1'b1, 32'h33, 32'h5A, 32'h0, 16'h0, -1);

    // unsupported funct3 behaves as no access with write-back suppressed
    do_op(5'd7, 1'b1, 32'h77, 4'b1011, 1'b0, 32'h50, 32'h0, 32'h0, 16'h0, -1);
    chk("unsup_wreg_lit", last_wreg, 0);
    do_op(5'd7, 1'b1, 32'h78, 4'b1110, 1'b0, 32'h50, 32'h0, 32'h0, 16'h0, -1);

    // misaligned word and halfword
    do_op(5'd10, 1'b1, 32'h0, 4'b1010, 1'b0, 32'h102, 32'h0, 32'hCAFEF00D, 16'h0, -1);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_flag_lit", last_mis, 1);
    chk("mis_noreq_lit", req_log.size(), 0);
`else
    chk("mis_flag_lit", last_mis, 0);
    chk("mis_nreq_lit", req_log.size(), 4);
    chk("mis_a0_lit", req_log[0].a, 32'h102);
    chk("mis_a3_lit", req_log[3].a, 32'h105);
    chk("mis_wdata_lit", last_wdata, 32'hCAFEF00D);
`endif
    do_op(5'd11, 1'b1, 32'h0, 4'b1001, 1'b0, 32'h101, 32'h0, 32'h1234, 16'h0, -1);

    // reset mid-LW after two acks, then the stage must be idle and usable
    do_op(5'd12, 1'b1, 32'h0, 4'b1010, 1'b0, 32'h400, 32'h0, 32'h11223344, 16'h0, 2);
    do_op(5'd9, 1'b1, 32'hBEEF, 4'b0000, 1'b0, 32'h0, 32'h0, 32'h0, 16'h0, -1);
    chk("post_rst_stall_lit", last_stall, 0);
    chk("post_rst_wdata_lit", last_wdata, 32'hBEEF);
    do_op(5'd13, 1'b1, 32'h0, 4'b1000, 1'b0, 32'h500, 32'h0, 32'h7F, 16'h0, -1);
    chk("post_rst_lb_lit", last_wdata, 32'h7F);
    chk("post_rst_lb_addr_lit", req_log[0].a, 32'h500);

    op_live  = 1'b0;
    in_memop = 4'b0000;
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
